// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for a 5-stage pipelined CPU.
//
// Keeps shadow copies of the register fields held in ID/EX, EX/MEM and MEM/WB.
// From these it drives the ALU operand forwarding selects, sequences load-use
// stalls and raises pipeline flushes on taken branches.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_*                    decoded fields of the instruction currently in ID
//   branch_taken_i          branch resolved taken in MEM
//   fwd_a_o, fwd_b_o        operand mux selects (0 regfile, 1 MEM/WB, 2 EX/MEM)
//   pc_write_o              PC update enable
//   ifid_write_o            IF/ID register enable
//   idex_bubble_o           zero control bits entering ID/EX
//   ifid_flush_o            clear IF/ID
//   idex_flush_o            clear ID/EX
//   exmem_flush_o           clear EX/MEM
//   stall_cnt_o             (HAZ_STATS_EN only) saturating count of stalled cycles
//   flush_cnt_o             (HAZ_STATS_EN only) saturating count of branch flushes
//
// Build option: define HAZ_STATS_EN to add the stall/flush statistics counters.
//
// FSM states
//   state | meaning
//   RUN   | pipeline flowing; a load-use hazard stalls the current cycle
//   STALL | extra load-use stall cycles while the counter runs down to zero

module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              branch_taken_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
`ifdef HAZ_STATS_EN
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o,
`endif
  output logic              exmem_flush_o
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } entry_t;

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  state_t     state_q, state_nxt;
  logic [1:0] cnt_q, cnt_nxt;
  entry_t     ex_q, mem_q, wb_q, id_entry;
  logic       hazard, stall, flush;

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid_i;
    id_entry.regwrite = id_regwrite_i;
    id_entry.memread  = id_memread_i;
    id_entry.use_rs   = id_use_rs_i;
    id_entry.use_rt   = id_use_rt_i;
    id_entry.rd       = id_rd_i;
    id_entry.rs       = id_rs_i;
    id_entry.rt       = id_rt_i;
  end

  // EX/MEM wins over MEM/WB; a load still in EX/MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input entry_t m, input entry_t w,
                                         input logic [REG_AW-1:0] src,
                                         input logic use_src);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_src && src != '0) begin
      if (m.valid && m.regwrite && !m.memread && m.rd == src)
        sel = 2'd2;
      else if (w.valid && w.regwrite && w.rd == src)
        sel = 2'd1;
    end
    return sel;
  endfunction

  assign hazard = id_valid_i && ex_q.valid && ex_q.memread && ex_q.rd != '0 &&
                  ((id_use_rs_i && id_rs_i == ex_q.rd) ||
                   (id_use_rt_i && id_rt_i == ex_q.rd));

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    stall     = 1'b0;
    flush     = 1'b0;
    if (!rst_i) begin
      if (branch_taken_i) begin
        flush     = 1'b1;
        state_nxt = RUN;
        cnt_nxt   = 2'd0;
      end else begin
        case (state_q)
          RUN: begin
            if (hazard) begin
              stall     = 1'b1;
              cnt_nxt   = CNT_INIT;
              state_nxt = (LOAD_LAT > 1) ? STALL : RUN;
            end
          end
          STALL: begin
            stall   = 1'b1;
            cnt_nxt = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
              cnt_nxt   = 2'd0;
              state_nxt = RUN;
            end
          end
          default: begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    fwd_a_o       = 2'd0;
    fwd_b_o       = 2'd0;
    if (!rst_i) begin
      fwd_a_o = fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.use_rs);
      fwd_b_o = fwd_sel(mem_q, wb_q, ex_q.rt, ex_q.use_rt);
    end
    pc_write_o    = !stall;
    ifid_write_o  = !stall;
    idex_bubble_o = stall;
    ifid_flush_o  = flush;
    idex_flush_o  = flush;
    exmem_flush_o = flush;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      wb_q    <= mem_q;
      if (flush) begin
        ex_q  <= '0;
        mem_q <= '0;
      end else begin
        ex_q  <= stall ? '0 : id_entry;
        mem_q <= ex_q;
      end
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      if (stall && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
      if (flush && flush_cnt_o != 16'hFFFF)
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0;
  logic       branch = 1'b0;

  logic [1:0] fwd_a [3];
  logic [1:0] fwd_b [3];
  logic       pc_write [3];
  logic       ifid_write [3];
  logic       bubble [3];
  logic       ifid_flush [3];
  logic       idex_flush [3];
  logic       exmem_flush [3];
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt [3];
  logic [15:0] flush_cnt [3];
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance g uses LOAD_LAT = g+1; all share the same stimulus.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.LOAD_LAT(g + 1), .REG_AW(5)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_valid_i    (id_valid),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_use_rs_i   (id_use_rs),
      .id_use_rt_i   (id_use_rt),
      .id_rd_i       (id_rd),
      .id_regwrite_i (id_regwrite),
      .id_memread_i  (id_memread),
      .branch_taken_i(branch),
      .fwd_a_o       (fwd_a[g]),
      .fwd_b_o       (fwd_b[g]),
      .pc_write_o    (pc_write[g]),
      .ifid_write_o  (ifid_write[g]),
      .idex_bubble_o (bubble[g]),
      .ifid_flush_o  (ifid_flush[g]),
      .idex_flush_o  (idex_flush[g]),
`ifdef HAZ_STATS_EN
      .stall_cnt_o   (stall_cnt[g]),
      .flush_cnt_o   (flush_cnt[g]),
`endif
      .exmem_flush_o (exmem_flush[g])
    );
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom); id_rd = 5'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom); branch = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    branch = 1'b0;
    nop();
  endtask

  task automatic chk_stalled(input int d, input string tag, input logic exp_stall);
    chk({tag, "_pc_write"}, 16'(pc_write[d]), 16'(!exp_stall));
    chk({tag, "_ifid_write"}, 16'(ifid_write[d]), 16'(!exp_stall));
    chk({tag, "_bubble"}, 16'(bubble[d]), 16'(exp_stall));
  endtask

  initial begin
    // Reset values, including while reset is held with a branch asserted.
    rst = 1'b1; branch = 1'b1;
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    chk("rst_hold_flush", 16'(ifid_flush[0]), 16'd0);
    chk("rst_hold_pc_write", 16'(pc_write[0]), 16'd1);
    do_reset();
    chk("rst_fwd_a", 16'(fwd_a[0]), 16'd0);
    chk("rst_fwd_b", 16'(fwd_b[0]), 16'd0);
    chk_stalled(0, "rst", 1'b0);
    chk("rst_ifid_flush", 16'(ifid_flush[0]), 16'd0);
    chk("rst_idex_flush", 16'(idex_flush[0]), 16'd0);
    chk("rst_exmem_flush", 16'(exmem_flush[0]), 16'd0);
`ifdef HAZ_STATS_EN
    chk("rst_stall_cnt", stall_cnt[0], 16'd0);
    chk("rst_flush_cnt", flush_cnt[0], 16'd0);
`endif

    // add $3,$1,$2 ; sub $5,$3,$4
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    chk_stalled(0, "exfwd_nostall", 1'b0);
    tick();
    nop();
    chk("exfwd_a", 16'(fwd_a[0]), 16'd2);
    chk("exfwd_b", 16'(fwd_b[0]), 16'd0);
    tick();
    chk("exfwd_a_after", 16'(fwd_a[0]), 16'd0);

    // add $3 ; nop ; or $6,$2,$3
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    nop();
    chk("memfwd_b", 16'(fwd_b[0]), 16'd1);
    chk("memfwd_a", 16'(fwd_a[0]), 16'd0);

    // add $3 ; add $3 ; or $6,$2,$3  -> EX/MEM wins
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    tick();
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    tick();
    nop();
    chk("prio_fwd_b", 16'(fwd_b[0]), 16'd2);

    // lw $2 ; add $4,$2,$2 on LOAD_LAT = 1, 2, 3
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk_stalled(0, "lu1_c0", 1'b1);
    chk_stalled(1, "lu2_c0", 1'b1);
    chk_stalled(2, "lu3_c0", 1'b1);
    tick();
    chk_stalled(0, "lu1_c1", 1'b0);
    chk_stalled(1, "lu2_c1", 1'b1);
    chk_stalled(2, "lu3_c1", 1'b1);
    tick();
    chk("lu1_fwd_a", 16'(fwd_a[0]), 16'd1);
    chk("lu1_fwd_b", 16'(fwd_b[0]), 16'd1);
    chk_stalled(1, "lu2_c2", 1'b0);
    chk_stalled(2, "lu3_c2", 1'b1);
    tick();
    chk_stalled(2, "lu3_c3", 1'b0);
`ifdef HAZ_STATS_EN
    chk("lu1_stall_cnt", stall_cnt[0], 16'd1);
    chk("lu3_stall_cnt", stall_cnt[2], 16'd3);
`endif

    // Register $0: add $0 ; sub $5,$0,$0 ; lw $0 ; add $4,$0,$0
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("r0_fwd_a", 16'(fwd_a[0]), 16'd0);
    chk("r0_fwd_b", 16'(fwd_b[0]), 16'd0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    chk_stalled(2, "r0_load", 1'b0);

    // Branch on the first stall cycle of a LOAD_LAT = 3 hazard.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    branch = 1'b1;
    #1;
    chk("br_ifid_flush", 16'(ifid_flush[2]), 16'd1);
    chk("br_idex_flush", 16'(idex_flush[2]), 16'd1);
    chk("br_exmem_flush", 16'(exmem_flush[2]), 16'd1);
    chk_stalled(2, "br_c0", 1'b0);
    tick();
    branch = 1'b0;
    nop();
    chk_stalled(2, "br_c1", 1'b0);
    chk("br_c1_flush", 16'(ifid_flush[2]), 16'd0);
`ifdef HAZ_STATS_EN
    chk("br_stall_cnt", stall_cnt[2], 16'd0);
    chk("br_flush_cnt", flush_cnt[2], 16'd1);
`endif

    // Branch while already in STALL: abandons the remaining stall cycles.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    chk_stalled(2, "brs_c1_pre", 1'b1);
    branch = 1'b1;
    #1;
    chk_stalled(2, "brs_c1", 1'b0);
    chk("brs_exmem_flush", 16'(exmem_flush[2]), 16'd1);
    tick();
    branch = 1'b0;
    #1;
    chk_stalled(2, "brs_c2", 1'b0);
`ifdef HAZ_STATS_EN
    chk("brs_stall_cnt", stall_cnt[2], 16'd1);
    chk("brs_flush_cnt", flush_cnt[2], 16'd1);
`endif

    // Reset mid-stall abandons the stall.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    tick();
    chk_stalled(2, "rs_pre", 1'b1);
    rst = 1'b1;
    #1;
    chk_stalled(2, "rs_during", 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk_stalled(2, "rs_after", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined CPU.
- Shadows the destination and source fields of instructions in ID/EX, EX/MEM and MEM/WB.
- Drives the 2-bit selects of the two 3-input ALU operand forwarding muxes.
- Sequences load-use stalls with a stall counter and generates pipeline flushes on taken branches.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (legal range 1..3)
REG_AW, 5, register address width

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  ID stage holds a real instruction
id_rs_i  in  REG_AW  ID source register A
id_rt_i  in  REG_AW  ID source register B
id_use_rs_i  in  1  ID instruction reads rs
id_use_rt_i  in  1  ID instruction reads rt
id_rd_i  in  REG_AW  ID destination (post-RegDst)
id_regwrite_i  in  1  ID instruction writes register file
id_memread_i  in  1  ID instruction is a load
branch_taken_i  in  1  branch resolved taken in MEM stage
fwd_a_o  out  2  operand A mux select: 0 = ID/EX regfile, 1 = MEM/WB data, 2 = EX/MEM ALU result
fwd_b_o  out  2  operand B mux select, same encoding
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID register enable
idex_bubble_o  out  1  zero control bits entering ID/EX
ifid_flush_o  out  1  clear IF/ID
idex_flush_o  out  1  clear ID/EX
exmem_flush_o  out  1  clear EX/MEM

Behaviour:
- Shadow entries: EX, MEM and WB. Each entry holds valid, regwrite, memread, rd, rs, rt, use_rs and use_rt.
- Per clock when not stalled: ID inputs shift into EX, EX into MEM, MEM into WB.
- During a stall: EX is loaded with an invalid entry (bubble); MEM and WB still advance.
- On a branch flush: EX and MEM are loaded invalid next cycle; WB takes the old MEM entry.
- Reset (synchronous, rst_i=1): all entries invalid; FSM returns to RUN; stall counter = 0.
  - Output values during and after reset: fwd_a_o = fwd_b_o = 0, pc_write_o = ifid_write_o = 1, all flush and bubble outputs = 0.
  - Reset mid-stall abandons the stall.
- Forwarding (combinational from shadow state only, zero latency, Moore style):
  - Select 2 when the EX/MEM entry is valid, regwrite=1, memread=0, rd != 0 and rd == EX.rs (or EX.rt for the B operand) with the matching use bit set.
  - Otherwise select 1 when the MEM/WB entry is valid, regwrite=1, rd != 0 and rd matches.
  - Otherwise select 0.
  - EX/MEM has priority over MEM/WB.
  - Register 0 never forwards.
  - A load in EX/MEM never yields select 2.
- Load-use detection (combinational): `hazard` = id_valid_i AND EX entry valid AND EX.memread AND EX.rd != 0 AND ((id_use_rs_i AND id_rs_i == EX.rd) OR (id_use_rt_i AND id_rt_i == EX.rd)).
- FSM, states RUN and STALL:
  - RUN: if hazard and no branch_taken_i, stall this cycle and go to STALL with counter = LOAD_LAT-1. If LOAD_LAT == 1, stay in RUN; the bubble then clears hazard.
  - STALL: stall each cycle; decrement the counter; return to RUN when the counter reaches 0.
  - Stall outputs: pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1.
  - Total stall = LOAD_LAT cycles per hazard.
- Branch: branch_taken_i = 1 asserts ifid_flush_o, idex_flush_o and exmem_flush_o in the same cycle; pc_write_o = 1.
  - Flush beats stall: a branch in RUN with hazard, or in STALL, forces RUN and counter = 0, with no bubble in that cycle.
- Flushed or bubbled entries never forward and never cause stalls.

Optional Feature:
- Macro: HAZ_STATS_EN.
- When defined:
  - Adds outputs stall_cnt_o[15:0] and flush_cnt_o[15:0], reset to 0.
  - stall_cnt_o increments once per stalled cycle; flush_cnt_o increments once per cycle with branch_taken_i = 1.
  - Both saturate at 16'hFFFF.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles with random inputs -> fwd_a_o = fwd_b_o = 0, pc_write_o = 1, all flushes and bubble = 0 on the first cycle after release.
- add $3 followed by sub $5,$3,$4 -> while sub is in EX, fwd_a_o = 2 for exactly that cycle; no stall.
- add $3; nop; or $6,$2,$3 -> fwd_b_o = 1 while or is in EX. Repeat with add $3 twice back-to-back -> select 2 wins.
- lw $2 followed by add $4,$2,$2, LOAD_LAT = 1 -> one cycle with pc_write_o = 0, ifid_write_o = 0, idex_bubble_o = 1; then fwd_a_o = fwd_b_o = 1. With LOAD_LAT = 2 -> two stalled cycles.
- Writes to $0 (add $0; sub $5,$0,$0; lw $0 then use of $0) -> selects stay 0, no stall.
- branch_taken_i = 1 during the first stall cycle of a LOAD_LAT = 3 hazard -> all three flushes = 1 with pc_write_o = 1 that cycle; next cycle FSM is in RUN with no stall. With HAZ_STATS_EN defined, stall_cnt_o = 0 (no stall occurred) and flush_cnt_o = 1.
